// File: rtl/instr_mem_sync.sv
// Programmable instruction memory with a req/ready fetch handshake, configurable wait states,
// and a NOP-plus-fault response for misaligned or out-of-range fetches.
module instr_mem_sync #(
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DEPTH       = 1024,
   parameter int unsigned       WAIT_CYCLES = 1,
   parameter logic [DATA_W-1:0] NOP_WORD    = '0,
   localparam int unsigned      IDX_W       = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [ADDR_W-1:0] addr,
   output logic              ready,
   output logic              valid,
   output logic [DATA_W-1:0] rdata,
   output logic              fault,
   input  logic              prog_we,
   input  logic [IDX_W-1:0]  prog_addr,
   input  logic [DATA_W-1:0] prog_data
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned FIDX_W = ADDR_W - 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic [ADDR_W-1:0] fetch_addr;
   logic [FIDX_W-1:0] fetch_idx;
   logic              fetch_fault;
   logic [DATA_W-1:0] rd_word;

   // Power-up contents are NOP_WORD everywhere; reset deliberately leaves the array alone.
   logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

   assign ready = (state_q == ST_IDLE) & ~rst;

   // With zero wait states RESP is entered on the accept edge, before addr_q holds the address.
   always_comb begin
      fetch_addr  = (state_q == ST_IDLE) ? addr : addr_q;
      fetch_idx   = fetch_addr[ADDR_W-1:2];
      fetch_fault = (fetch_addr[1:0] != 2'b00) || (fetch_idx >= FIDX_W'(DEPTH));
      rd_word     = fetch_fault ? NOP_WORD : mem[fetch_idx[IDX_W-1:0]];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               addr_d = addr;
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
               end else begin
                  cnt_d   = CNT_W'(WAIT_CYCLES);
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Response registers capture on the edge entering RESP and hold until the next response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         valid   <= 1'b0;
         rdata   <= '0;
         fault   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         valid   <= (state_d == ST_RESP);
         if (state_d == ST_RESP) begin
            rdata <= rd_word;
            fault <= fetch_fault;
         end
      end
   end

   // Program port; the capture above reads the pre-write word on a coincident edge.
   always_ff @(posedge clk) begin
      if (prog_we && !rst && (32'(prog_addr) < DEPTH)) begin
         mem[prog_addr] <= prog_data;
      end
   end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Scoreboard bench for instr_mem_sync: three instances (1, 0 and 3 wait states) share clock and reset.
module tb_instr_mem_sync;

   localparam int unsigned NI = 3;

   typedef struct {
      int          inst;
      logic [31:0] data;
      logic        flt;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req [NI];
   logic [31:0] addr [NI];
   logic        ready [NI];
   logic        valid [NI];
   logic [31:0] rdata [NI];
   logic        fault [NI];
   logic        prog_we [NI];
   logic [9:0]  prog_addr [NI];
   logic [31:0] prog_data [NI];

   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;
   int   wc [NI] = '{1, 0, 3};
   exp_t sb [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   instr_mem_sync #(.WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .rst(rst), .req(req[0]), .addr(addr[0]), .ready(ready[0]), .valid(valid[0]),
      .rdata(rdata[0]), .fault(fault[0]), .prog_we(prog_we[0]), .prog_addr(prog_addr[0]),
      .prog_data(prog_data[0]));

   instr_mem_sync #(.WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .rst(rst), .req(req[1]), .addr(addr[1]), .ready(ready[1]), .valid(valid[1]),
      .rdata(rdata[1]), .fault(fault[1]), .prog_we(prog_we[1]), .prog_addr(prog_addr[1]),
      .prog_data(prog_data[1]));

   instr_mem_sync #(.WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .rst(rst), .req(req[2]), .addr(addr[2]), .ready(ready[2]), .valid(valid[2]),
      .rdata(rdata[2]), .fault(fault[2]), .prog_we(prog_we[2]), .prog_addr(prog_addr[2]),
      .prog_data(prog_data[2]));

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s inst=%0d got=%h expected=%h", name, k, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic prog(input int k, input logic [9:0] a, input logic [31:0] d);
      prog_we[k] = 1'b1; prog_addr[k] = a; prog_data[k] = d;
      tick(1);
      prog_we[k] = 1'b0;
   endtask

   // Issues one accepted fetch; returns in the first cycle after the accept edge.
   task automatic fetch(input int k, input logic [31:0] a, input bit expect_rsp,
                        input logic [31:0] d, input logic f);
      exp_t e;
      chk("ready_before_accept", k, 32'(ready[k]), 32'd1);
      req[k] = 1'b1; addr[k] = a;
      tick(1);
      req[k] = 1'b0;
      if (expect_rsp) begin
         e.inst = k; e.data = d; e.flt = f; e.due = cyc + wc[k];
         sb.push_back(e);
      end
   endtask

   task automatic wait_idle(input int k);
      int n;
      n = 0;
      while (ready[k] !== 1'b1 && n < 50) begin
         tick(1);
         n++;
      end
      if (n >= 50) begin
         checks++; fails++;
         $display("FAIL wait_idle_timeout inst=%0d got=ready_low expected=ready_high", k);
      end
   endtask

   // Monitor: every valid pulse must match the oldest outstanding expectation for its instance.
   initial begin
      int   idx;
      exp_t e;
      forever begin
         @(negedge clk);
         for (int k = 0; k < int'(NI); k++) begin
            if (valid[k] === 1'b1) begin
               idx = -1;
               foreach (sb[i]) if (idx < 0 && sb[i].inst == k) idx = i;
               if (idx < 0) begin
                  checks++; fails++;
                  $display("FAIL unexpected_valid inst=%0d got=valid rdata=%h expected=no_valid", k, rdata[k]);
               end else begin
                  e = sb[idx];
                  sb.delete(idx);
                  chk("rsp_rdata", k, rdata[k], e.data);
                  chk("rsp_fault", k, 32'(fault[k]), 32'(e.flt));
                  chk("rsp_latency", k, 32'(cyc), 32'(e.due));
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      for (int k = 0; k < int'(NI); k++) begin
         req[k] = 1'b0; addr[k] = '0; prog_we[k] = 1'b0; prog_addr[k] = '0; prog_data[k] = '0;
      end
      tick(2);
      for (int k = 0; k < int'(NI); k++) begin
         chk("reset_ready", k, 32'(ready[k]), 32'd0);
         chk("reset_valid", k, 32'(valid[k]), 32'd0);
         chk("reset_rdata", k, rdata[k], 32'd0);
         chk("reset_fault", k, 32'(fault[k]), 32'd0);
      end
      rst = 1'b0;
      #1;
      chk("ready_after_reset", 0, 32'(ready[0]), 32'd1);

      // T1: programmed word fetched with one wait state, then held after valid falls
      prog(0, 10'd1, 32'h8001060A);
      fetch(0, 32'd4, 1'b1, 32'h8001060A, 1'b0);
      wait_idle(0);
      tick(2);
      chk("hold_rdata", 0, rdata[0], 32'h8001060A);
      chk("hold_valid_low", 0, 32'(valid[0]), 32'd0);

      // T3: misaligned, past-the-end, and last valid word
      fetch(0, 32'd6, 1'b1, 32'h0, 1'b1);
      wait_idle(0);
      fetch(0, 32'd4096, 1'b1, 32'h0, 1'b1);
      wait_idle(0);
      prog(0, 10'd1023, 32'h12345678);
      fetch(0, 32'd4092, 1'b1, 32'h12345678, 1'b0);
      wait_idle(0);

      // T6: request during WAIT and RESP is ignored
      fetch(0, 32'd4, 1'b1, 32'h8001060A, 1'b0);
      chk("ready_in_wait", 0, 32'(ready[0]), 32'd0);
      req[0] = 1'b1; addr[0] = 32'd4092;
      tick(2);
      req[0] = 1'b0;
      tick(4);

      // T2: zero wait states with req held high
      prog(1, 10'd2, 32'hCAFE0002);
      req[1] = 1'b1; addr[1] = 32'd8;
      for (int i = 0; i < 6; i++) begin
         exp_t e;
         chk("t2_ready_toggle", 1, 32'(ready[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
         tick(1);
         if (i % 2 == 0) begin
            e.inst = 1; e.data = 32'hCAFE0002; e.flt = 1'b0; e.due = cyc;
            sb.push_back(e);
         end
      end
      req[1] = 1'b0;
      tick(2);

      // T4: write at accept+2 is seen; writes on or after the capture edge are not
      prog(2, 10'd0, 32'h11111111);
      fetch(2, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0);
      tick(1);
      prog(2, 10'd0, 32'hDEADBEEF);
      wait_idle(2);
      fetch(2, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0);
      tick(3);
      prog(2, 10'd0, 32'h0BADF00D);
      wait_idle(2);
      fetch(2, 32'd0, 1'b1, 32'h0BADF00D, 1'b0);
      tick(2);
      prog(2, 10'd0, 32'h5EED5EED);
      wait_idle(2);
      fetch(2, 32'd0, 1'b1, 32'h5EED5EED, 1'b0);
      wait_idle(2);

      // T5: reset one cycle into a fetch aborts it; memory survives, writes during reset dropped
      prog(2, 10'd3, 32'hA5A5A5A5);
      fetch(2, 32'd12, 1'b0, 32'h0, 1'b0);
      rst = 1'b1;
      prog_we[2] = 1'b1; prog_addr[2] = 10'd3; prog_data[2] = 32'hFFFFFFFF;
      #1;
      chk("ready_low_in_rst", 2, 32'(ready[2]), 32'd0);
      tick(1);
      rst = 1'b0; prog_we[2] = 1'b0;
      #1;
      chk("ready_after_rst_drop", 2, 32'(ready[2]), 32'd1);
      chk("rdata_cleared_by_rst", 2, rdata[2], 32'd0);
      tick(6);
      fetch(2, 32'd12, 1'b1, 32'hA5A5A5A5, 1'b0);
      wait_idle(2);

      tick(8);
      chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
